// File: rtl/nibble_packer.sv
// Packs pairs of DATA_W-bit words into 2*DATA_W-bit bytes on a valid/ready port,
// with flush-to-pad and a byte counter. Define NIBBLE_PACKER_PARITY_EN for out_parity.
module nibble_packer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   out_data,
    output logic                  out_pad,
    input  logic                  out_ready,
    output logic                  out_parity,
    output logic [CNT_W-1:0]      byte_cnt
);

    localparam int unsigned OUT_W = 2 * DATA_W;

    typedef enum logic {EMPTY, HALF} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q;
    logic                out_pad_q;
    logic [CNT_W-1:0]    byte_cnt_q;

    logic                slot_open;
    logic                in_fire;
    logic                out_fire;
    logic                load_en;
    logic                load_pad;
    logic [OUT_W-1:0]    load_data;

    // Next-state, byte-load and handshake decode
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        load_en   = 1'b0;
        load_pad  = 1'b0;
        load_data = '0;
        slot_open = !out_valid_q || out_ready;
        in_ready  = (state_q == EMPTY) || slot_open;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid_q && out_ready;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    lo_d    = in_data;
                    state_d = HALF;
                end
            end
            HALF: begin
                if (in_fire) begin
                    load_en   = 1'b1;
                    load_data = {in_data, lo_q};
                    state_d   = EMPTY;
                end else if (flush && slot_open && !in_valid) begin
                    load_en   = 1'b1;
                    load_pad  = 1'b1;
                    load_data = {{DATA_W{1'b0}}, lo_q};
                    state_d   = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        out_valid_d = load_en || (out_valid_q && !out_ready);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_pad_q   <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
            if (load_en) begin
                out_data_q <= load_data;
                out_pad_q  <= load_pad;
            end
            if (out_fire) begin
                byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef NIBBLE_PACKER_PARITY_EN
    logic parity_q;

    // Parity travels with the byte it was computed from
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (load_en) begin
            parity_q <= ^load_data;
        end
    end

    assign out_parity = parity_q;
`else
    assign out_parity = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_pad   = out_pad_q;
    assign byte_cnt  = byte_cnt_q;

endmodule
